// File: rtl/dmem_stall_ctrl.sv
// rtl/dmem_stall_ctrl.sv - MEM-stage data-memory access sequencer with pipeline stall and timeout
//
// Purpose:
//   Sits between the EXE/MEM register and a slow data memory. A load or store
//   seen in IDLE is latched and presented to the memory with a req/ready
//   handshake while the upstream pipeline (PC, IF/ID, ID/EXE, EXE/MEM) is
//   frozen and the MEM/WB write-back is suppressed. After completion (or a
//   timeout) a single DONE cycle releases the pipeline.
//
// Ports:
//   clk            pipeline clock, all state on rising edge
//   clrn           asynchronous reset, active-high
//   mem_wmem       MEM-stage store flag
//   mem_m2reg      MEM-stage load flag
//   mem_Alu_Result MEM-stage effective address
//   mem_rb         MEM-stage store data
//   dm_ready       memory completion strobe (only looked at in ACCESS)
//   dm_rdata       memory read data, valid with dm_ready
//   dm_req         access request to memory
//   dm_we          write enable to memory (qualified by dm_req)
//   dm_addr        latched address
//   dm_wdata       latched store data
//   stall          freeze upstream pipeline registers and PC
//   wb_bubble      force mem_wreg=0 into MEM/WB
//   ld_data        captured load data
//   bus_err        one-cycle timeout pulse (high during the error DONE cycle)
//   wait_cnt       ACCESS cycles elapsed (debug)

module dmem_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             mem_wmem,
  input  logic             mem_m2reg,
  input  logic [31:0]      mem_Alu_Result,
  input  logic [31:0]      mem_rb,
  input  logic             dm_ready,
  input  logic [31:0]      dm_rdata,
  output logic             dm_req,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             stall,
  output logic             wb_bubble,
  output logic [31:0]      ld_data,
  output logic             bus_err,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state, state_nxt;

  logic access;
  logic we_q;
  logic cap;       // latch the MEM-stage access this cycle
  logic rd_done;   // memory completed this cycle
  logic tmo;       // last allowed ACCESS cycle passed without ready
  logic cnt_inc;

  assign access = mem_wmem | mem_m2reg;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dm_req    = 1'b0;
    stall     = 1'b0;
    wb_bubble = 1'b0;
    cap       = 1'b0;
    rd_done   = 1'b0;
    tmo       = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        // Stall must rise in the detect cycle itself so EXE/MEM holds the
        // access until it has been completed.
        if (access) begin
          stall     = 1'b1;
          wb_bubble = 1'b1;
          cap       = 1'b1;
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        dm_req    = 1'b1;
        stall     = 1'b1;
        wb_bubble = 1'b1;
        if (dm_ready) begin
          rd_done   = 1'b1;
          state_nxt = S_DONE;
        end else if (wait_cnt == CNT_LAST) begin
          tmo       = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        // access is ignored here: EXE/MEM still holds the same instruction.
        // bus_err doubles as the "ended in error" flag for this cycle.
        wb_bubble = bus_err;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // While reset is held the pipeline must not stay frozen, even though the
    // MEM-stage flags may still show an access.
    if (clrn) begin
      dm_req    = 1'b0;
      stall     = 1'b0;
      wb_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      dm_addr  <= '0;
      dm_wdata <= '0;
      we_q     <= 1'b0;
      ld_data  <= '0;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (cap) begin
        dm_addr  <= mem_Alu_Result;
        dm_wdata <= mem_rb;
        we_q     <= mem_wmem;  // store wins when both flags are set
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + CNT_ONE;
      end
      if (rd_done && !we_q) begin
        ld_data <= dm_rdata;
      end
      // Set on the timeout edge, so it is high exactly for the DONE cycle.
      bus_err <= tmo;
    end
  end

  assign dm_we = we_q & dm_req;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb/tb_dmem_stall_ctrl.sv - scoreboard bench for dmem_stall_ctrl
module tb_dmem_stall_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;
  localparam int NEVER   = 1000;

  logic             clk = 1'b0;
  logic             clrn;
  logic             mem_wmem, mem_m2reg;
  logic [31:0]      mem_Alu_Result, mem_rb;
  logic             dm_ready;
  logic [31:0]      dm_rdata;
  logic             dm_req, dm_we, stall, wb_bubble, bus_err;
  logic [31:0]      dm_addr, dm_wdata, ld_data;
  logic [CNT_W-1:0] wait_cnt;

  dmem_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn),
    .mem_wmem(mem_wmem), .mem_m2reg(mem_m2reg),
    .mem_Alu_Result(mem_Alu_Result), .mem_rb(mem_rb),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .stall(stall), .wb_bubble(wb_bubble), .ld_data(ld_data),
    .bus_err(bus_err), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        we;
    logic        err;
    int          stall_len;
    int          req_len;
    int          wcnt;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cur_lat = NEVER;
  logic [31:0] cur_rdata = '0;
  logic [31:0] exp_ld = '0;
  bit          skip = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: ready arrives in ACCESS cycle number cur_lat (0-based);
  // outside ACCESS, ready and rdata are noise that must be ignored.
  initial begin
    int acc_cyc;
    acc_cyc  = 0;
    dm_ready = 1'b0;
    dm_rdata = '0;
    forever begin
      @(negedge clk);
      if (dm_req) begin
        dm_ready = (acc_cyc == cur_lat);
        dm_rdata = (acc_cyc == cur_lat) ? cur_rdata : $urandom;
        acc_cyc++;
      end else begin
        acc_cyc  = 0;
        dm_ready = $urandom_range(0, 1) == 1;
        dm_rdata = $urandom;
      end
    end
  end

  // Monitor: tracks each stall run and checks the completion cycle against
  // the next expected transaction.
  initial begin
    bit          prev_stall;
    int          run, req_run;
    logic [31:0] cap_a, cap_d;
    logic        cap_we;
    bit          hold_bad, cnt_bad, bub_bad, berr_bad;
    exp_t        e;
    prev_stall = 1'b0;
    run = 0; req_run = 0; cap_a = '0; cap_d = '0; cap_we = 1'b0;
    hold_bad = 0; cnt_bad = 0; bub_bad = 0; berr_bad = 0;
    forever begin
      @(negedge clk);
      if (skip) begin
        prev_stall = 1'b0;
      end else if (stall) begin
        if (!prev_stall) begin
          chk("stall_has_access", sb.size() != 0, 1);
          run = 0; req_run = 0;
          hold_bad = 0; cnt_bad = 0; bub_bad = 0; berr_bad = 0;
        end
        run++;
        if (wb_bubble !== 1'b1) bub_bad = 1;
        if (bus_err !== 1'b0) berr_bad = 1;
        if (dm_req) begin
          if (req_run == 0) begin
            cap_a = dm_addr; cap_d = dm_wdata; cap_we = dm_we;
          end else if (dm_addr !== cap_a || dm_wdata !== cap_d || dm_we !== cap_we) begin
            hold_bad = 1;
          end
          if (int'(wait_cnt) != req_run) cnt_bad = 1;
          req_run++;
        end
        prev_stall = 1'b1;
      end else if (prev_stall) begin
        if (sb.size() == 0) begin
          chk("done_expected", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("stall_len", run, e.stall_len);
          chk("req_len", req_run, e.req_len);
          chk("dm_addr", cap_a, e.addr);
          chk("dm_wdata", cap_d, e.wdata);
          chk("dm_we", cap_we, e.we);
          chk("hold_stable", hold_bad, 0);
          chk("wait_cnt_seq", cnt_bad, 0);
          chk("bubble_in_stall", bub_bad, 0);
          chk("bus_err_in_stall", berr_bad, 0);
          chk("ld_data", ld_data, e.ld);
          chk("done_wb_bubble", wb_bubble, e.err);
          chk("done_bus_err", bus_err, e.err);
          chk("done_wait_cnt", wait_cnt, e.wcnt);
          chk("done_dm_req", dm_req, 0);
        end
        prev_stall = 1'b0;
      end else begin
        chk("idle_ctrl", {dm_req, wb_bubble, bus_err}, 3'b000);
      end
    end
  end

  // Drive one MEM-stage instruction and hold it until the pipeline advances.
  task automatic issue(input logic wm, input logic m2, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    mem_wmem = wm; mem_m2reg = m2; mem_Alu_Result = a; mem_rb = wd;
    cur_lat = lat; cur_rdata = rd;
    if (wm | m2) begin
      e.err       = (lat >= TIMEOUT);
      e.req_len   = e.err ? TIMEOUT : lat + 1;
      e.stall_len = e.req_len + 1;
      e.wcnt      = e.err ? TIMEOUT - 1 : lat;
      e.we        = wm;
      e.addr      = a;
      e.wdata     = wd;
      if (!e.err && !wm) exp_ld = rd;
      e.ld        = exp_ld;
      sb.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("complete_in_budget", 0, 1);
  endtask

  initial begin
    int r, lat, kind;
    clrn = 1'b1;
    mem_wmem = 0; mem_m2reg = 0; mem_Alu_Result = '0; mem_rb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {dm_req, dm_we, stall, wb_bubble, bus_err}, 5'b0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_ld", ld_data, 0);
    chk("rst_wcnt", wait_cnt, 0);
    clrn = 1'b0;
    @(posedge clk); #1;
    skip = 1'b0;

    for (int i = 0; i < 5; i++) issue(0, 0, $urandom, $urandom, 0, $urandom);
    issue(0, 1, 32'h0000_0040, $urandom, 0, 32'hDEAD_BEEF);
    issue(1, 0, 32'h0000_0010, 32'h1234_5678, 3, $urandom);
    issue(0, 1, 32'h0000_0004, $urandom, 0, 32'hA5A5_0004);
    issue(0, 1, 32'h0000_0008, $urandom, 1, 32'h5A5A_0008);
    issue(0, 1, 32'h0000_0100, $urandom, NEVER, 32'hBAD0_BAD0);
    issue(0, 1, 32'h0000_0104, $urandom, TIMEOUT - 1, 32'h600D_600D);
    issue(1, 1, 32'h0000_0108, 32'hCAFE_F00D, 2, 32'h0BAD_CAFE);
    issue(1, 0, 32'h0000_010C, 32'h7777_0000, NEVER, $urandom);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      r    = $urandom_range(0, 9);
      lat  = (r == 0) ? NEVER : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
      issue(kind[1], kind[0], $urandom, $urandom, lat, $urandom);
    end

    // Reset during the second ACCESS cycle of a load that never completes.
    @(posedge clk); #1;
    skip = 1'b1;
    mem_wmem = 0; mem_m2reg = 1; mem_Alu_Result = 32'h0000_0200; cur_lat = NEVER;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_rst_req", dm_req, 1);
    chk("pre_rst_wcnt", wait_cnt, 1);
    clrn = 1'b1;
    #1;
    chk("mid_rst_req", dm_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_wcnt", wait_cnt, 0);
    @(negedge clk);
    mem_m2reg = 0;
    clrn = 1'b0;
    exp_ld = '0;
    @(negedge clk);
    chk("post_rst_idle", {dm_req, stall, wb_bubble}, 3'b000);
    @(posedge clk); #1;
    skip = 1'b0;
    issue(0, 1, 32'h0000_0204, $urandom, 1, 32'h1357_9BDF);
    issue(0, 0, '0, '0, 0, '0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage pipeline.
- The data memory is slow (variable wait states, ready handshake); this block sits between the EXE/MEM register outputs and the memory.
- It latches the access, drives the memory handshake, freezes the pipeline (PC, IF/ID, ID/EXE, EXE/MEM) until completion, and suppresses MEM/WB write-back while stalled.
- It bounds each access with a timeout.

Parameters:
TIMEOUT, 16, max ACCESS cycles without dm_ready before abort (>=2)
CNT_W, 5, width of wait counter; must hold TIMEOUT

Ports:
clk  in  1  pipeline clock, all state on rising edge
clrn  in  1  reset; asynchronous, active-high (1 = reset)
mem_wmem  in  1  MEM-stage store flag
mem_m2reg  in  1  MEM-stage load flag
mem_Alu_Result  in  32  MEM-stage effective address
mem_rb  in  32  MEM-stage store data
dm_ready  in  1  memory completion strobe, sampled only in ACCESS
dm_rdata  in  32  memory read data, valid with dm_ready
dm_req  out  1  access request to memory
dm_we  out  1  write enable to memory
dm_addr  out  32  latched address
dm_wdata  out  32  latched store data
stall  out  1  freeze upstream pipeline registers and PC
wb_bubble  out  1  force mem_wreg=0 into MEM/WB
ld_data  out  32  captured load data
bus_err  out  1  one-cycle timeout pulse
wait_cnt  out  CNT_W  ACCESS cycles elapsed (debug)

Behaviour:
- Reset (clrn=1, async): state IDLE; dm_addr, dm_wdata, ld_data, wait_cnt = 0; dm_we latch = 0; bus_err = 0. Resulting outputs: dm_req=0, stall=0, wb_bubble=0.
- Definition: access = mem_wmem | mem_m2reg.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - access=0: all outputs 0, stay IDLE.
  - access=1: stall=1 and wb_bubble=1 (combinational); latch dm_addr←mem_Alu_Result, dm_wdata←mem_rb, dm_we←mem_wmem (store wins if both flags set); wait_cnt←0; go ACCESS.
- ACCESS:
  - dm_req=1, stall=1, wb_bubble=1.
  - dm_addr, dm_wdata, dm_we held constant.
  - dm_ready=1: ld_data←dm_rdata (loads only; stores leave ld_data unchanged); go DONE.
  - Else if wait_cnt==TIMEOUT-1: bus_err←1; go DONE flagged as error.
  - Else wait_cnt+1.
- DONE (exactly one cycle):
  - dm_req=0, stall=0, so the pipeline advances at the end of this cycle.
  - wb_bubble=0 on normal completion; 1 on error (suppresses the load write-back).
  - ld_data valid for MEM/WB capture.
  - access is ignored here, because it still reflects the same instruction.
  - Next state IDLE; bus_err cleared.
- Latency: a zero-wait access stalls 2 cycles (IDLE-detect + ACCESS) and completes in DONE. Each memory wait state adds 1 stall cycle.
- Back-to-back accesses: the next instruction is sampled in IDLE the cycle after DONE; no idle gap beyond that.
- dm_ready outside ACCESS is ignored.
- Reset mid-ACCESS: immediate return to IDLE with dm_req=0 and stall=0; the in-flight access is abandoned.
- wait_cnt never wraps; it saturates at TIMEOUT-1 by construction.

Test Plan:
- Non-memory instruction (wmem=0, m2reg=0) for 5 cycles -> stall=0, dm_req=0 throughout.
- Load addr 0x0000_0040, dm_ready in first ACCESS cycle, rdata 0xDEAD_BEEF -> stall high 2 cycles; DONE shows ld_data=0xDEAD_BEEF, wb_bubble=0.
- Store addr 0x10 data 0x1234_5678, dm_ready after 3 wait cycles -> dm_we=1 and dm_addr/dm_wdata stable for 4 ACCESS cycles; stall high 5 cycles.
- Two consecutive loads (0x4 then 0x8) -> two complete IDLE→ACCESS→DONE sequences; second dm_addr=0x8 latched the cycle after the first DONE.
- Load, dm_ready never asserted, TIMEOUT=16 -> 16 ACCESS cycles; bus_err pulses one cycle; DONE has wb_bubble=1; then returns to IDLE.
- clrn asserted during the 2nd ACCESS cycle -> dm_req, stall, wait_cnt go to 0 asynchronously; after release, state is IDLE.
